// File: rtl/si_pkg.sv
// rtl/si_pkg.sv - shared Space Invaders timing constants and scheduler state type
package si_pkg;

  // VGA frame geometry shared with the timing block
  localparam int HPIXELS      = 832;
  localparam int VLINES       = 509;
  // Cycles of vertical blanking available for game updates (28 lines)
  localparam int BLANK_BUDGET = 23296;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } sched_state_t;

endpackage

// File: rtl/frame_sched_timer.sv
// rtl/frame_sched_timer.sv - per-task wait counter flagging the last allowed cycle
module frame_sched_timer #(
  parameter int TIMEOUT = 4096
) (
  input  logic dclk,
  input  logic clr,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [TW-1:0] count;

  // Count cycles spent waiting; cleared on each new task issue
  always_ff @(posedge dclk) begin
    if (clr || clear) begin
      count <= '0;
    end else if (run) begin
      count <= count + TW'(1);
    end
  end

  assign expired = (count == TW'(TIMEOUT - 1));

endmodule

// File: rtl/frame_scheduler.sv
// rtl/frame_scheduler.sv - per-frame ordered game task sequencer triggered by vsync
module frame_scheduler #(
  parameter int NUM_TASKS = 4,
  parameter int TIMEOUT   = 4096,
  parameter int FCW       = 16,
  localparam int IW       = (NUM_TASKS > 1) ? $clog2(NUM_TASKS) : 1
) (
  input  logic                 dclk,
  input  logic                 clr,
  input  logic                 vsync,
  input  logic                 enable,
  input  logic [NUM_TASKS-1:0] task_done,
  output logic [NUM_TASKS-1:0] task_start,
  output logic [IW-1:0]        cur_task,
  output logic                 busy,
  output logic [FCW-1:0]       frame_count,
  output logic [7:0]           overrun_count,
  output logic [NUM_TASKS-1:0] err_mask
);

  import si_pkg::*;

  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_TASKS - 1);

  sched_state_t  state, state_n;
  logic [IW-1:0] idx, idx_n;
  logic          vsync_q;
  logic          trigger;
  logic          timer_clear, timer_run, expired;
  logic          frame_inc, err_set, ovr_inc;

  // Falling edge of active-low vsync marks the start of blanking
  assign trigger = vsync_q && !vsync;
  assign ovr_inc = trigger && (state != IDLE);

  frame_sched_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .dclk    (dclk),
    .clr     (clr),
    .clear   (timer_clear),
    .run     (timer_run),
    .expired (expired)
  );

  // State, task index and vsync history registers
  always_ff @(posedge dclk) begin
    if (clr) begin
      state   <= IDLE;
      idx     <= '0;
      vsync_q <= 1'b1;
    end else begin
      state   <= state_n;
      idx     <= idx_n;
      vsync_q <= vsync;
    end
  end

  // Sequencing: issue each task once, advance on its done or on timeout (done wins)
  always_comb begin
    state_n     = state;
    idx_n       = idx;
    timer_clear = 1'b0;
    timer_run   = 1'b0;
    frame_inc   = 1'b0;
    err_set     = 1'b0;
    case (state)
      IDLE: begin
        if (trigger && enable) begin
          idx_n   = '0;
          state_n = ISSUE;
        end
      end
      ISSUE: begin
        timer_clear = 1'b1;
        state_n     = WAIT;
      end
      WAIT: begin
        timer_run = 1'b1;
        if (task_done[idx] || expired) begin
          err_set = !task_done[idx];
          if (idx == LAST_IDX) begin
            frame_inc = 1'b1;
            state_n   = IDLE;
          end else begin
            idx_n   = idx + IW'(1);
            state_n = ISSUE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Frame, overrun and sticky timeout bookkeeping
  always_ff @(posedge dclk) begin
    if (clr) begin
      frame_count   <= '0;
      overrun_count <= '0;
      err_mask      <= '0;
    end else begin
      if (frame_inc) begin
        frame_count <= frame_count + FCW'(1);
      end
      if (ovr_inc && (overrun_count != 8'hFF)) begin
        overrun_count <= overrun_count + 8'd1;
      end
      if (err_set) begin
        err_mask[idx] <= 1'b1;
      end
    end
  end

  // One-hot start pulse decoded from the single-cycle ISSUE state
  always_comb begin
    task_start = '0;
    if (state == ISSUE) begin
      task_start[idx] = 1'b1;
    end
  end

  assign busy     = (state != IDLE);
  assign cur_task = idx;

endmodule

// File: tb/tb_frame_scheduler.sv
// tb/tb_frame_scheduler.sv - randomized and directed self-checking bench for frame_scheduler
module tb_frame_scheduler;

  localparam int NT    = 4;
  localparam int TO    = 16;
  localparam int NEVER = 255;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        clr = 1'b1;
  logic        vsync = 1'b1;
  logic        enable = 1'b0;
  logic [3:0]  task_done = 4'b0;
  logic [3:0]  task_start;
  logic [1:0]  cur_task;
  logic        busy;
  logic [15:0] frame_count;
  logic [7:0]  overrun_count;
  logic [3:0]  err_mask;

  frame_scheduler #(.NUM_TASKS(NT), .TIMEOUT(TO), .FCW(16)) dut (
    .dclk          (clk),
    .clr           (clr),
    .vsync         (vsync),
    .enable        (enable),
    .task_done     (task_done),
    .task_start    (task_start),
    .cur_task      (cur_task),
    .busy          (busy),
    .frame_count   (frame_count),
    .overrun_count (overrun_count),
    .err_mask      (err_mask)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int lat[4];

  // Reference model: sequence in flight, current task, absolute cycle of its start pulse
  bit          m_valid = 0;
  bit          m_busy  = 0;
  bit          m_vprev = 1;
  int          m_cur   = 0;
  int          m_start = -1000;
  logic [15:0] m_frames = '0;
  int          m_over  = 0;
  logic [3:0]  m_err   = '0;

  bit          hist_busy[int];
  logic [15:0] hist_frame[int];
  logic [3:0]  hist_start[int];
  logic [1:0]  hist_cur[int];
  int          log_cyc[$];
  logic [3:0]  log_vec[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
  endtask

  task automatic model_step(input logic c_clr, input logic c_vs, input logic c_en, input logic [3:0] d);
    bit trig, fin;
    if (c_clr) begin
      m_valid = 1; m_busy = 0; m_cur = 0; m_start = -1000;
      m_frames = '0; m_over = 0; m_err = '0; m_vprev = 1;
    end else begin
      trig    = m_vprev && !c_vs;
      m_vprev = c_vs;
      if (!m_busy) begin
        if (trig && c_en) begin
          m_busy = 1; m_cur = 0; m_start = cyc + 1;
        end
      end else begin
        if (trig && m_over != 255) m_over++;
        if (cyc > m_start) begin
          fin = d[m_cur];
          if (!fin && cyc == m_start + TO) begin
            m_err[m_cur] = 1'b1;
            fin = 1;
          end
          if (fin) begin
            if (m_cur == NT - 1) begin
              m_busy = 0;
              m_frames++;
            end else begin
              m_cur++;
              m_start = cyc + 1;
            end
          end
        end
      end
    end
  endtask

  task automatic tick(input logic c_clr, input logic c_vs, input logic c_en, input logic [3:0] noise);
    logic [3:0] d, es;
    @(negedge clk);
    hist_busy[cyc]  = busy;
    hist_frame[cyc] = frame_count;
    hist_start[cyc] = task_start;
    hist_cur[cyc]   = cur_task;
    if (m_valid) begin
      es = '0;
      if (m_busy && cyc == m_start) es[m_cur] = 1'b1;
      check("task_start", 32'(task_start), 32'(es));
      check("busy", 32'(busy), 32'(m_busy));
      check("cur_task", 32'(cur_task), 32'(m_cur));
      check("frame_count", 32'(frame_count), 32'(m_frames));
      check("overrun_count", 32'(overrun_count), 32'(m_over));
      check("err_mask", 32'(err_mask), 32'(m_err));
    end
    if (task_start != 4'b0) begin
      log_cyc.push_back(cyc);
      log_vec.push_back(task_start);
    end
    d = noise;
    if (m_busy) begin
      d[m_cur] = 1'b0;
      if (lat[m_cur] != NEVER && cyc == m_start + lat[m_cur]) d[m_cur] = 1'b1;
    end
    clr = c_clr; vsync = c_vs; enable = c_en; task_done = d;
    model_step(c_clr, c_vs, c_en, d);
    cyc++;
  endtask

  task automatic reset_dut();
    tick(1, 1, 1, 4'b0);
    tick(1, 1, 1, 4'b0);
    tick(0, 1, 1, 4'b0);
    tick(0, 1, 1, 4'b0);
  endtask

  task automatic frame(input logic en, input int n, output int t0);
    t0 = cyc;
    for (int k = 0; k < n; k++) tick(0, (k < 4) ? 1'b0 : 1'b1, en, 4'b0);
  endtask

  initial begin
    int t0, t1, vs_cnt, r;
    logic vs_lvl;
    int exp_c[4];
    logic [3:0] exp_v[4];
    exp_c = '{1, 5, 9, 13};
    exp_v = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    lat = '{3, 3, 3, 3};

    // Reset
    tick(1, 1, 1, 4'b0);
    tick(1, 1, 1, 4'b0);
    tick(0, 1, 1, 4'b0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cur", 32'(cur_task), 32'd0);
    check("rst_start", 32'(task_start), 32'd0);
    check("rst_frames", 32'(frame_count), 32'd0);
    check("rst_over", 32'(overrun_count), 32'd0);
    check("rst_err", 32'(err_mask), 32'd0);

    // Normal frame: done 3 cycles after each start
    log_cyc.delete(); log_vec.delete();
    frame(1, 22, t0);
    check("norm_nstarts", 32'(log_cyc.size()), 32'd4);
    if (log_cyc.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        check("norm_start_cyc", 32'(log_cyc[i] - t0), 32'(exp_c[i]));
        check("norm_start_vec", 32'(log_vec[i]), 32'(exp_v[i]));
      end
    end
    check("norm_busy16", 32'(hist_busy[t0 + 16]), 32'd1);
    check("norm_busy17", 32'(hist_busy[t0 + 17]), 32'd0);
    check("norm_frames17", 32'(hist_frame[t0 + 17]), 32'd1);
    check("norm_err", 32'(err_mask), 32'd0);

    // Timeout on task 2
    reset_dut();
    lat = '{2, 2, NEVER, 2};
    log_cyc.delete(); log_vec.delete();
    frame(1, 32, t0);
    check("to_nstarts", 32'(log_cyc.size()), 32'd4);
    if (log_cyc.size() == 4) begin
      check("to_start2", 32'(log_cyc[2] - t0), 32'd7);
      check("to_gap", 32'(log_cyc[3] - log_cyc[2]), 32'd17);
    end
    check("to_err", 32'(err_mask), 32'b0100);
    check("to_frames", 32'(frame_count), 32'd1);
    lat = '{2, 2, 2, 2};
    frame(1, 20, t1);
    check("to_err_sticky", 32'(err_mask), 32'b0100);
    check("to_frames2", 32'(frame_count), 32'd2);

    // Overrun while task 1 is waiting, then saturation
    reset_dut();
    lat = '{2, 10, 2, 2};
    t0 = cyc;
    tick(0, 0, 1, 4'b0);
    tick(0, 0, 1, 4'b0);
    for (int k = 0; k < 4; k++) tick(0, 1, 1, 4'b0);
    for (int k = 0; k < 3; k++) tick(0, 0, 1, 4'b0);
    for (int k = 0; k < 20; k++) tick(0, 1, 1, 4'b0);
    check("ovr_cur_at_trig", 32'(hist_cur[t0 + 6]), 32'd1);
    check("ovr_count", 32'(overrun_count), 32'd1);
    check("ovr_frames", 32'(frame_count), 32'd1);
    check("ovr_busy_end", 32'(busy), 32'd0);
    lat = '{NEVER, NEVER, NEVER, NEVER};
    for (int k = 0; k < 300; k++) begin
      tick(0, 0, 1, 4'b0);
      tick(0, 1, 1, 4'b0);
    end
    check("ovr_sat", 32'(overrun_count), 32'd255);
    for (int k = 0; k < 80; k++) tick(0, 1, 1, 4'b0);

    // Enable low
    reset_dut();
    lat = '{2, 2, 2, 2};
    log_cyc.delete(); log_vec.delete();
    frame(0, 12, t0);
    check("en_nstarts", 32'(log_cyc.size()), 32'd0);
    check("en_busy", 32'(busy), 32'd0);
    check("en_frames", 32'(frame_count), 32'd0);
    check("en_over", 32'(overrun_count), 32'd0);
    t0 = cyc;
    tick(0, 0, 1, 4'b0);
    for (int k = 1; k < 26; k++) tick(0, (k < 4) ? 1'b0 : 1'b1, 1'b0, 4'b0);
    check("en_mid_frames", 32'(frame_count), 32'd1);
    check("en_mid_nstarts", 32'(log_cyc.size()), 32'd4);

    // Reset while waiting on task 1
    reset_dut();
    lat = '{2, NEVER, 2, 2};
    t0 = cyc;
    tick(0, 0, 1, 4'b0);
    for (int k = 1; k < 8; k++) tick(0, (k < 4) ? 1'b0 : 1'b1, 1, 4'b0);
    check("rmid_waiting", 32'(hist_cur[t0 + 7]), 32'd1);
    tick(1, 1, 1, 4'b0);
    tick(0, 1, 1, 4'b0);
    check("rmid_busy", 32'(hist_busy[t0 + 9]), 32'd0);
    check("rmid_start", 32'(hist_start[t0 + 9]), 32'd0);
    check("rmid_frames", 32'(hist_frame[t0 + 9]), 32'd0);
    check("rmid_cur", 32'(hist_cur[t0 + 9]), 32'd0);
    tick(0, 1, 1, 4'b0);
    lat = '{2, 2, 2, 16};
    log_cyc.delete(); log_vec.delete();
    frame(1, 32, t1);
    if (log_vec.size() > 0) begin
      check("rmid_first_vec", 32'(log_vec[0]), 32'b0001);
      check("rmid_first_cyc", 32'(log_cyc[0] - t1), 32'd1);
    end else begin
      check("rmid_nstarts", 32'(log_vec.size()), 32'd4);
    end
    check("tie_err", 32'(err_mask), 32'd0);
    check("tie_frames", 32'(frame_count), 32'd1);

    // Randomized traffic against the model
    reset_dut();
    vs_lvl = 1'b1;
    vs_cnt = 5;
    for (int i = 0; i < 4000; i++) begin
      if (vs_cnt == 0) begin
        vs_lvl = !vs_lvl;
        vs_cnt = vs_lvl ? $urandom_range(2, 90) : $urandom_range(1, 6);
        if (!vs_lvl) begin
          for (int j = 0; j < NT; j++) begin
            r = $urandom_range(0, 9);
            case (r)
              0: lat[j] = 0;
              1: lat[j] = NEVER;
              2: lat[j] = TO;
              3: lat[j] = TO - 1;
              4: lat[j] = TO + 1;
              default: lat[j] = $urandom_range(1, 6);
            endcase
          end
        end
      end else begin
        vs_cnt--;
      end
      tick(($urandom_range(0, 999) == 0), vs_lvl, ($urandom_range(0, 9) != 0), 4'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
